// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable framing, per-frame error flags and a show-ahead receive FIFO.
// Define UART_RX_MAJORITY_VOTE_EN for 2-of-3 majority sampling around each mid-bit point.
`timescale 1ns/1ps
module uart_rx_fifo #(
   parameter int CLK_FREQ    = 10_000_000,
   parameter int BAUD_RATE   = 115200,
   parameter int DATA_BITS   = 8,
   parameter int PARITY_MODE = 0,
   parameter int STOP_BITS   = 1,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 rx_i,
   output logic [DATA_BITS-1:0] rx_data_o,
   output logic                 rx_valid_o,
   input  logic                 rx_ready_i,
   output logic                 frame_err_o,
   output logic                 parity_err_o,
   output logic                 overrun_o,
   output logic                 busy_o
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);
   localparam int PTR_W        = $clog2(FIFO_DEPTH);
   localparam int ENTRY_W      = DATA_BITS + 2;

   // The start-bit decision is pulled in by the synchroniser and detect latency so
   // that the first data decision lands one full bit later at the nominal latency.
   localparam logic [CNT_W-1:0] START_TICK = CNT_W'(HALF_BIT - 2);
   localparam logic [CNT_W-1:0] BIT_TICK   = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [3:0]       LAST_DATA  = 4'(DATA_BITS - 1);
   localparam logic [3:0]       LAST_STOP  = 4'(STOP_BITS - 1);
   localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

   state_t               state, state_next;
   logic                 rx_meta, rxs, rxs_d1;
   logic                 sample, tick, push;
   logic [CNT_W-1:0]     cnt;
   logic [3:0]           bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 frame_err, parity_err;
   logic [ENTRY_W-1:0]   entry, head;

   logic [ENTRY_W-1:0]   mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr, rd_ptr;
   logic [PTR_W:0]       count;
   logic                 full, pop, wr_en;

`ifdef UART_RX_MAJORITY_VOTE_EN
   logic rxs_d2;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) rxs_d2 <= 1'b1;
      else        rxs_d2 <= rxs_d1;
   end

   // Decision cycle sees three consecutive rxs values centred on rxs_d1.
   assign sample = (rxs & rxs_d1) | (rxs & rxs_d2) | (rxs_d1 & rxs_d2);
`else
   assign sample = rxs_d1;
`endif

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
         rxs_d1  <= 1'b1;
      end else begin
         rx_meta <= rx_i;
         rxs     <= rx_meta;
         rxs_d1  <= rxs;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state <= IDLE;
      else        state <= state_next;
   end

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_next = state;
      push       = 1'b0;
      tick       = (state == START) ? (cnt == START_TICK) : (cnt == BIT_TICK);
      case (state)
         IDLE:      if (!rxs) state_next = START;
         START:     if (tick) state_next = sample ? IDLE : DATA;
         DATA:      if (tick && bit_cnt == LAST_DATA)
                       state_next = (PARITY_MODE != 0) ? PARITY : STOP;
         PARITY:    if (tick) state_next = STOP;
         STOP:      if (tick && bit_cnt == LAST_STOP) begin
                       push       = 1'b1;
                       state_next = sample ? IDLE : WAIT_HIGH;
                    end
         WAIT_HIGH: if (rxs) state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt        <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         if (state == IDLE || state == WAIT_HIGH || tick) cnt <= '0;
         else                                             cnt <= cnt + 1'b1;

         if (state_next != state)                         bit_cnt <= '0;
         else if (tick && (state == DATA || state == STOP)) bit_cnt <= bit_cnt + 1'b1;

         if (state == DATA && tick) shreg <= {sample, shreg[DATA_BITS-1:1]};

         if (state == IDLE) begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
         end else begin
            if (state == STOP && tick && !sample) frame_err <= 1'b1;
            if (state == PARITY && tick)
               parity_err <= (PARITY_MODE == 2) ? ~(^shreg ^ sample) : (^shreg ^ sample);
         end
      end
   end

   // The final stop sample is folded in directly because frame_err updates on the same edge.
   assign entry = {frame_err | ~sample, parity_err, shreg};

   assign full  = (count == FULL_COUNT);
   assign pop   = rx_valid_o & rx_ready_i;
   assign wr_en = push & (~full | pop);

   // NOTE: storage has no reset; outputs are gated by count so stale contents never leak out.
   always_ff @(posedge clk_i) begin
      if (wr_en) mem[wr_ptr] <= entry;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overrun_o <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         overrun_o <= push & full & ~pop;
      end
   end

   assign head         = mem[rd_ptr];
   assign rx_valid_o   = (count != '0);
   assign rx_data_o    = rx_valid_o ? head[DATA_BITS-1:0] : '0;
   assign parity_err_o = rx_valid_o & head[DATA_BITS];
   assign frame_err_o  = rx_valid_o & head[DATA_BITS+1];
   assign busy_o       = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: default 8N1 instance plus an even-parity, two-stop-bit instance.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

   localparam int BIT_NS = 8680;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx_a, rx_b, ready_a, ready_b;
   logic [7:0] data_a, data_b;
   logic       valid_a, valid_b, ferr_a, ferr_b, perr_a, perr_b;
   logic       ovr_a, ovr_b, busy_a, busy_b;

   int         n_checks = 0;
   int         n_errors = 0;
   int         cyc = 0;
   int         fall_cyc, rise_cyc;
   logic       valid_a_prev = 1'b0;
   logic       busy_at_rise, busy_seen_a;
   int         ovr_cnt_a = 0;
   int         ovr_cnt_b = 0;
   logic [9:0] q_a[$];
   logic [9:0] q_b[$];

   always #50 clk = ~clk;

   uart_rx_fifo dut_a (
      .clk_i(clk), .rst_i(rst_n), .rx_i(rx_a), .rx_data_o(data_a), .rx_valid_o(valid_a),
      .rx_ready_i(ready_a), .frame_err_o(ferr_a), .parity_err_o(perr_a), .overrun_o(ovr_a),
      .busy_o(busy_a)
   );

   uart_rx_fifo #(.PARITY_MODE(1), .STOP_BITS(2)) dut_b (
      .clk_i(clk), .rst_i(rst_n), .rx_i(rx_b), .rx_data_o(data_b), .rx_valid_o(valid_b),
      .rx_ready_i(ready_b), .frame_err_o(ferr_b), .parity_err_o(perr_b), .overrun_o(ovr_b),
      .busy_o(busy_b)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: records every accepted head entry as {frame_err, parity_err, data}.
   always @(negedge clk) begin
      if (valid_a && ready_a) q_a.push_back({ferr_a, perr_a, data_a});
      if (valid_b && ready_b) q_b.push_back({ferr_b, perr_b, data_b});
      if (ovr_a) ovr_cnt_a = ovr_cnt_a + 1;
      if (ovr_b) ovr_cnt_b = ovr_cnt_b + 1;
      if (busy_a) busy_seen_a = 1'b1;
      if (valid_a && !valid_a_prev) begin
         rise_cyc     = cyc;
         busy_at_rise = busy_a;
      end
      valid_a_prev = valid_a;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tx_a(input logic [7:0] d);
      rx_a = 1'b0;
      #BIT_NS;
      for (int i = 0; i < 8; i++) begin
         rx_a = d[i];
         #BIT_NS;
      end
      rx_a = 1'b1;
      #(2 * BIT_NS);
   endtask

   task automatic tx_b(input logic [7:0] d, input logic par, input logic stop2);
      rx_b = 1'b0;
      #BIT_NS;
      for (int i = 0; i < 8; i++) begin
         rx_b = d[i];
         #BIT_NS;
      end
      rx_b = par;
      #BIT_NS;
      rx_b = 1'b1;
      #BIT_NS;
      rx_b = stop2;
      #BIT_NS;
      rx_b = 1'b1;
      #(2 * BIT_NS);
   endtask

   initial begin
      rst_n   = 1'b0;
      rx_a    = 1'b1;
      rx_b    = 1'b1;
      ready_a = 1'b1;
      ready_b = 1'b1;
      busy_seen_a = 1'b0;
      #520;
      check("rst_valid",   {31'd0, valid_a}, 32'd0);
      check("rst_data",    {24'd0, data_a},  32'd0);
      check("rst_busy",    {31'd0, busy_a},  32'd0);
      check("rst_ovr",     {31'd0, ovr_a},   32'd0);
      check("rst_flags",   {30'd0, ferr_a, perr_a}, 32'd0);
      rst_n = 1'b1;
      #1000;

      // 1: clean 8N1 frame with consumer always ready.
      @(posedge clk);
      #1;
      fall_cyc = cyc;
      tx_a(8'h33);
      check("t1_count",    q_a.size(),        32'd1);
      check("t1_entry",    {22'd0, q_a[0]},   {22'd0, 10'h033});
      check("t1_latency",  {31'd0, ((rise_cyc - fall_cyc) >= 818) && ((rise_cyc - fall_cyc) <= 820)}, 32'd1);
      check("t1_busy_mid", {31'd0, busy_seen_a},  32'd1);
      check("t1_busy_end", {31'd0, busy_at_rise}, 32'd0);
      check("t1_valid_end", {31'd0, valid_a},     32'd0);
      q_a.delete();

      // 2: 20-clock low glitch must be rejected as a false start.
      rx_a = 1'b0;
      #1000;
      check("t2_busy_start", {31'd0, busy_a}, 32'd1);
      #1000;
      rx_a = 1'b1;
      #(2 * BIT_NS);
      check("t2_busy_idle",  {31'd0, busy_a},  32'd0);
      check("t2_no_push",    q_a.size(),       32'd0);
      check("t2_valid",      {31'd0, valid_a}, 32'd0);

      // 3: break condition yields exactly one frame-error entry, then a clean frame.
      rx_a = 1'b0;
      #150_000;
      check("t3_busy_wait",  {31'd0, busy_a},  32'd1);
      check("t3_one_entry",  q_a.size(),       32'd1);
      check("t3_entry",      {22'd0, q_a[0]},  {22'd0, 10'h200});
      #50_000;
      rx_a = 1'b1;
      #(2 * BIT_NS);
      check("t3_busy_idle",  {31'd0, busy_a},  32'd0);
      check("t3_still_one",  q_a.size(),       32'd1);
      tx_a(8'hA5);
      check("t3_count",      q_a.size(),       32'd2);
      check("t3_next",       {22'd0, q_a[1]},  {22'd0, 10'h0A5});
      q_a.delete();

      // 4: fill the FIFO with the consumer stalled; the fifth frame overruns.
      ready_a   = 1'b0;
      ovr_cnt_a = 0;
      tx_a(8'h55);
      tx_a(8'hAA);
      tx_a(8'hFF);
      tx_a(8'h0F);
      check("t4_no_ovr_yet", ovr_cnt_a,        32'd0);
      tx_a(8'hF0);
      check("t4_ovr_pulse",  ovr_cnt_a,        32'd1);
      check("t4_valid",      {31'd0, valid_a}, 32'd1);
      check("t4_head",       {24'd0, data_a},  32'h55);
      @(posedge clk);
      #1;
      ready_a = 1'b1;
      #2000;
      check("t4_pops",       q_a.size(),       32'd4);
      check("t4_pop0",       {22'd0, q_a[0]},  {22'd0, 10'h055});
      check("t4_pop1",       {22'd0, q_a[1]},  {22'd0, 10'h0AA});
      check("t4_pop2",       {22'd0, q_a[2]},  {22'd0, 10'h0FF});
      check("t4_pop3",       {22'd0, q_a[3]},  {22'd0, 10'h00F});
      check("t4_empty",      {31'd0, valid_a}, 32'd0);
      q_a.delete();

      // 5: even parity, two stop bits.
      tx_b(8'h55, 1'b0, 1'b1);
      tx_b(8'h55, 1'b1, 1'b1);
      tx_b(8'h55, 1'b0, 1'b0);
      check("t5_count",      q_b.size(),       32'd3);
      check("t5_par_ok",     {22'd0, q_b[0]},  {22'd0, 10'h055});
      check("t5_par_err",    {22'd0, q_b[1]},  {22'd0, 10'h155});
      check("t5_stop2_err",  {22'd0, q_b[2]},  {22'd0, 10'h255});
      check("t5_no_ovr",     ovr_cnt_b,        32'd0);
      check("t5_busy_idle",  {31'd0, busy_b},  32'd0);

      // 6: async reset in the middle of data bit 3 with two entries queued.
      ready_a = 1'b0;
      tx_a(8'h11);
      tx_a(8'h22);
      check("t6_queued",     {31'd0, valid_a}, 32'd1);
      check("t6_head",       {24'd0, data_a},  32'h11);
      rx_a = 1'b0;
      #BIT_NS;
      rx_a = 1'b1;
      #(3 * BIT_NS);
      rx_a = 1'b0;
      #4000;
      rst_n = 1'b0;
      #1;
      check("t6_rst_valid",  {31'd0, valid_a}, 32'd0);
      check("t6_rst_data",   {24'd0, data_a},  32'd0);
      check("t6_rst_busy",   {31'd0, busy_a},  32'd0);
      rx_a = 1'b1;
      #1000;
      rst_n = 1'b1;
      #(2 * BIT_NS);
      check("t6_fifo_empty", {31'd0, valid_a}, 32'd0);
      ready_a = 1'b1;
      tx_a(8'h3C);
      check("t6_count",      q_a.size(),       32'd1);
      check("t6_after",      {22'd0, q_a[0]},  {22'd0, 10'h03C});

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
